reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit resettable register (flopr-style storage, held internally) between N_REQ requesters.
- Each requester presents write data and a request. The arbiter grants one requester, writes its data into the shared register and pulses an acknowledge.
- A requester may lock the register for back-to-back writes, bounded by a lock timeout.
- Sits between CPU-side sources (e.g. debug port, ALU writeback, loader) and a shared state register.

Parameters:
- WIDTH, 8, data width of the shared register.
- N_REQ, 4, number of requesters; legal range 2..8.
- MAX_LOCK, 8, maximum consecutive cycles spent in OWN before a lock is forcibly released; legal range ≥1.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, release is sampled on clock.
- req  input  N_REQ  per-requester write request, bit i = requester i.
- lock  input  N_REQ  per-requester lock request, meaningful only for the current owner.
- wdata  input  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  registered one-hot grant; all-zero when idle.
- ack  output  N_REQ  registered one-cycle pulse marking the cycle the register took requester i's data.
- q  output  WIDTH  shared register contents.
- q_owner  output  clog2(N_REQ)  index of the last requester that wrote q.
- busy  output  1  high while in OWN.

Behaviour:
- Reset (reset=0, asynchronous): state=ARB, ptr=0, lock_cnt=0, grant=0, ack=0, q=0, q_owner=0, busy=0.
- Winner selection (combinational, ARB only):
  - w = first index with req set, scanning ptr, ptr+1, … modulo N_REQ.
  - With req=0 there is no winner.
- State ARB, rising edge with a winner:
  - q<=wdata[w]; q_owner<=w; ack<=onehot(w); grant<=onehot(w); ptr<=(w+1) mod N_REQ.
  - If lock[w]=1: state<=OWN, lock_cnt<=0, busy<=1.
  - Else: state stays ARB.
- State ARB, rising edge with no winner: grant<=0, ack<=0; q, q_owner and ptr hold.
- ARB grant lifetime: grant lasts exactly one cycle unless OWN is entered. Grant and ack therefore assert in the same cycle as the new q value (one-cycle latency from request to write).
- State OWN, owner o=q_owner; every rising edge:
  - lock_cnt<=lock_cnt+1.
  - If req[o]=1: q<=wdata[o], ack<=onehot(o).
  - Else: ack<=0 and q holds.
  - Requests and locks from non-owners are ignored. ptr is not updated.
- OWN exit: on an edge where lock[o]=0 or lock_cnt==MAX_LOCK-1:
  - state<=ARB, grant<=0, busy<=0.
  - A write on that same edge (req[o]=1) still occurs.
  - The next arbitration starts from ptr, which already points past the owner, so the owner has lowest priority.
- While in OWN, grant stays onehot(o).
- The lock input is ignored in ARB for non-winners.
- Reset asserted mid-OWN aborts the lock immediately. Outputs go to reset values and no write is lost-or-replayed semantics apply; the pending write is simply dropped.
- Simultaneous events:
  - All requesters asserting req chain grants in rotation ptr, ptr+1, … (fairness: any continuously requesting requester is granted within N_REQ arbitrations).
  - Wrap from index N_REQ-1 to 0 is mandatory.
- Invariants:
  - grant and ack are always zero or one-hot.
  - ack is never asserted for an index not in grant.

Test Plan:
- Reset: hold reset=0 with random inputs, then release → grant=0, ack=0, q=0, q_owner=0, busy=0. Assert reset=0 asynchronously between edges → outputs clear before the next edge.
- Single requester, WIDTH=8: req=4'b0100, wdata[2]=8'hA5 for one cycle → after the edge q=8'hA5, grant=ack=4'b0100, q_owner=2. Following cycle grant=0.
- Round-robin wrap: req=4'b1111 held, distinct data 8'h10/11/12/13 → grants 0001,0010,0100,1000,0001 on consecutive edges, with q following the matching data.
- Lock: req0+lock0 held 3 cycles with data 8'h01,02,03, req1 also held → grant=0001 for 3 writes, busy=1, req1 ignored. Drop lock0 → next arbitration grants requester 1.
- Lock timeout, MAX_LOCK=8: requester 3 holds req+lock indefinitely while requester 0 requests → OWN exits after 8 OWN cycles, busy falls, and requester 0 is granted on the next edge.
- Reset mid-OWN: in OWN with owner 1, pulse reset=0 → state returns to ARB, q=0, ptr=0. After release, req=4'b0011 → requester 0 is granted first.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Bundle of requester-side and register-side signals for reg_write_arbiter.
//   req     : per-requester write request (bit i = requester i)
//   lock    : per-requester lock request, honoured only for the current owner
//   wdata   : packed write data, requester i at [i*WIDTH +: WIDTH]
//   grant   : registered one-hot grant, zero when idle
//   ack     : registered one-cycle pulse when q took requester i's data
//   q       : shared register contents
//   q_owner : index of the requester that last wrote q
//   busy    : high while a requester holds the lock
// The master modport is the requester side; the slave modport is the arbiter.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic [IDX_W-1:0]       q_owner;
  logic                   busy;

  modport master (
    output req, lock, wdata,
    input  grant, ack, q, q_owner, busy
  );

  modport slave (
    input  req, lock, wdata,
    output grant, ack, q, q_owner, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between N_REQ requesters.
// A winning requester may lock the register for back-to-back writes; the lock
// is released when the owner drops lock or after MAX_LOCK cycles in OWN.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : reg_write_arbiter_if.slave (req/lock/wdata in; grant/ack/q/q_owner/busy out)
module reg_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N_REQ    = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  reg_write_arbiter_if.slave    bus
);
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CAND_W = IDX_W + 1;
  localparam int CNT_W  = $clog2(MAX_LOCK + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic {ARB, OWN} state_t;

  state_t            state_reg,    state_next;
  logic [IDX_W-1:0]  ptr_reg,      ptr_next;
  logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;
  logic [N_REQ-1:0]  grant_reg,    grant_next;
  logic [N_REQ-1:0]  ack_reg,      ack_next;
  logic [WIDTH-1:0]  q_reg,        q_next;
  logic [IDX_W-1:0]  owner_reg,    owner_next;

  // Per-requester view of the packed write data.
  logic [WIDTH-1:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wdata
    assign wdata_arr[gi] = bus.wdata[gi*WIDTH +: WIDTH];
  end

  // Winner search: scan offsets from highest to lowest so the lowest offset
  // from ptr (highest priority) is the last one written.
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [CAND_W-1:0] cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + CAND_W'(k);
      if (cand >= CAND_W'(N_REQ)) begin
        cand = cand - CAND_W'(N_REQ);
      end
      if (bus.req[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lock_cnt_next = lock_cnt_reg;
    grant_next    = grant_reg;
    ack_next      = ack_reg;
    q_next        = q_reg;
    owner_next    = owner_reg;

    case (state_reg)
      ARB: begin
        if (win_valid) begin
          q_next     = wdata_arr[win_idx];
          owner_next = win_idx;
          grant_next = ONE_HOT0 << win_idx;
          ack_next   = ONE_HOT0 << win_idx;
          ptr_next   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (bus.lock[win_idx]) begin
            state_next    = OWN;
            lock_cnt_next = '0;
          end
        end else begin
          grant_next = '0;
          ack_next   = '0;
        end
      end

      OWN: begin
        // ptr already points past the owner, so the owner gets lowest
        // priority once arbitration resumes.
        lock_cnt_next = lock_cnt_reg + 1'b1;
        if (bus.req[owner_reg]) begin
          q_next   = wdata_arr[owner_reg];
          ack_next = ONE_HOT0 << owner_reg;
        end else begin
          ack_next = '0;
        end
        // On the release edge the grant drops immediately, but a write
        // presented on that edge still lands and is acknowledged.
        if (!bus.lock[owner_reg] || lock_cnt_reg == CNT_W'(MAX_LOCK - 1)) begin
          state_next = ARB;
          grant_next = '0;
        end
      end

      default: begin
        state_next = ARB;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      lock_cnt_reg <= '0;
      grant_reg    <= '0;
      ack_reg      <= '0;
      q_reg        <= '0;
      owner_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lock_cnt_reg <= lock_cnt_next;
      grant_reg    <= grant_next;
      ack_reg      <= ack_next;
      q_reg        <= q_next;
      owner_reg    <= owner_next;
    end
  end

  assign bus.grant   = grant_reg;
  assign bus.ack     = ack_reg;
  assign bus.q       = q_reg;
  assign bus.q_owner = owner_reg;
  assign bus.busy    = (state_reg == OWN);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (WIDTH=8, N_REQ=4, MAX_LOCK=8).
// Each step pushes the expected outputs to a scoreboard, drives inputs,
// and after the clock edge pops and compares against the DUT.
module tb_reg_write_arbiter;
  localparam int WIDTH    = 8;
  localparam int N_REQ    = 4;
  localparam int MAX_LOCK = 8;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] ack;
    logic [7:0] q;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  exp_t  sb[$];
  string sb_tag[$];

  reg_write_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  reg_write_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_LOCK(MAX_LOCK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] pack(input logic [7:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push(input logic [3:0] eg, ea, input logic [7:0] eq,
                      input logic [1:0] eo, input logic eb, input string tag);
    exp_t e;
    e.grant = eg; e.ack = ea; e.q = eq; e.owner = eo; e.busy = eb;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  // Pop the oldest expectation and compare against the current DUT outputs.
  task automatic cmp_now();
    exp_t  e;
    string t;
    compared++;
    assert (sb.size() > 0) else begin
      mismatched++;
      $error("FAIL scoreboard: observed empty, expected entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      compared++;
      assert (bus.grant === e.grant) else begin
        mismatched++;
        $error("FAIL %s grant: observed %b expected %b", t, bus.grant, e.grant);
      end
      compared++;
      assert (bus.ack === e.ack) else begin
        mismatched++;
        $error("FAIL %s ack: observed %b expected %b", t, bus.ack, e.ack);
      end
      compared++;
      assert (bus.q === e.q) else begin
        mismatched++;
        $error("FAIL %s q: observed %h expected %h", t, bus.q, e.q);
      end
      compared++;
      assert (bus.q_owner === e.owner) else begin
        mismatched++;
        $error("FAIL %s q_owner: observed %0d expected %0d", t, bus.q_owner, e.owner);
      end
      compared++;
      assert (bus.busy === e.busy) else begin
        mismatched++;
        $error("FAIL %s busy: observed %b expected %b", t, bus.busy, e.busy);
      end
      compared++;
      assert ($onehot0(bus.grant) && $onehot0(bus.ack)) else begin
        mismatched++;
        $error("FAIL %s onehot: observed grant %b ack %b expected zero-or-one-hot",
               t, bus.grant, bus.ack);
      end
      $display("step %-12s req=%b lock=%b -> grant=%b ack=%b q=%h owner=%0d busy=%b",
               t, bus.req, bus.lock, bus.grant, bus.ack, bus.q, bus.q_owner, bus.busy);
    end
  endtask

  // One clocked transaction: push expectation, drive, clock, compare.
  task automatic cyc(input logic [3:0] r, l, input logic [31:0] wd,
                     input logic [3:0] eg, ea, input logic [7:0] eq,
                     input logic [1:0] eo, input logic eb, input string tag);
    push(eg, ea, eq, eo, eb, tag);
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = wd;
    @(posedge clock);
    #1;
    cmp_now();
  endtask

  initial begin
    logic [7:0] rr_q  [6];
    logic [3:0] rr_g  [6];
    logic [1:0] rr_o  [6];
    compared   = 0;
    mismatched = 0;

    // Reset held with random inputs.
    reset     = 1'b0;
    bus.req   = 4'($urandom);
    bus.lock  = 4'($urandom);
    bus.wdata = $urandom;
    repeat (3) @(posedge clock);
    #1;
    push(4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, "reset_hold");
    cmp_now();
    @(negedge clock);
    reset = 1'b1;
    cyc(4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, "reset_rel");

    // Single requester.
    cyc(4'b0100, 4'b0000, pack(8'h00, 8'hA5, 8'h00, 8'h00),
        4'b0100, 4'b0100, 8'hA5, 2'd2, 1'b0, "single");
    cyc(4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0, "single_idle");

    // Round robin with all requesting; ptr is 3 after the single grant.
    rr_g = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_q = '{8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rr_o = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1111, 4'b0000, pack(8'h13, 8'h12, 8'h11, 8'h10),
          rr_g[i], rr_g[i], rr_q[i], rr_o[i], 1'b0, $sformatf("rr%0d", i));
    end
    cyc(4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h10, 2'd0, 1'b0, "rr_idle");
    // Move ptr to 0.
    cyc(4'b1000, 4'b0000, pack(8'h33, 8'h00, 8'h00, 8'h00),
        4'b1000, 4'b1000, 8'h33, 2'd3, 1'b0, "ptr_to0");

    // Lock by requester 0 while requester 1 also requests.
    cyc(4'b0011, 4'b0001, pack(8'h00, 8'h00, 8'hB1, 8'h01),
        4'b0001, 4'b0001, 8'h01, 2'd0, 1'b1, "lock_w1");
    cyc(4'b0011, 4'b0001, pack(8'h00, 8'h00, 8'hB1, 8'h02),
        4'b0001, 4'b0001, 8'h02, 2'd0, 1'b1, "lock_w2");
    cyc(4'b0011, 4'b0001, pack(8'h00, 8'h00, 8'hB1, 8'h03),
        4'b0001, 4'b0001, 8'h03, 2'd0, 1'b1, "lock_w3");
    // Drop lock: release edge still writes, grant drops.
    cyc(4'b0011, 4'b0000, pack(8'h00, 8'h00, 8'hB1, 8'h04),
        4'b0000, 4'b0001, 8'h04, 2'd0, 1'b0, "lock_rel");
    cyc(4'b0011, 4'b0000, pack(8'h00, 8'h00, 8'hB1, 8'h05),
        4'b0010, 4'b0010, 8'hB1, 2'd1, 1'b0, "after_lock");

    // Lock timeout: ptr=2, requester 3 wins and holds lock forever.
    cyc(4'b1001, 4'b1000, pack(8'hC0, 8'h00, 8'h00, 8'hD0),
        4'b1000, 4'b1000, 8'hC0, 2'd3, 1'b1, "to_enter");
    for (int k = 1; k <= MAX_LOCK; k++) begin
      cyc(4'b1001, 4'b1000, pack(8'hC0 + 8'(k), 8'h00, 8'h00, 8'hD0),
          (k < MAX_LOCK) ? 4'b1000 : 4'b0000, 4'b1000, 8'hC0 + 8'(k), 2'd3,
          (k < MAX_LOCK), $sformatf("to_own%0d", k));
    end
    cyc(4'b1001, 4'b1000, pack(8'hCF, 8'h00, 8'h00, 8'hD0),
        4'b0001, 4'b0001, 8'hD0, 2'd0, 1'b0, "to_next");

    // Reset mid-OWN with owner 1 (ptr=1).
    cyc(4'b0010, 4'b0010, pack(8'h00, 8'h00, 8'hE1, 8'h00),
        4'b0010, 4'b0010, 8'hE1, 2'd1, 1'b1, "own1_enter");
    cyc(4'b0010, 4'b0010, pack(8'h00, 8'h00, 8'hE2, 8'h00),
        4'b0010, 4'b0010, 8'hE2, 2'd1, 1'b1, "own1_write");
    @(negedge clock);
    bus.wdata = pack(8'h00, 8'h00, 8'hE3, 8'h00);
    reset = 1'b0;
    #1;
    push(4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, "async_rst");
    cmp_now();
    @(posedge clock);
    #1;
    push(4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, "rst_held");
    cmp_now();
    @(negedge clock);
    reset = 1'b1;
    cyc(4'b0011, 4'b0000, pack(8'h00, 8'h00, 8'hE4, 8'h5A),
        4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b0, "post_rst");
    cyc(4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h5A, 2'd0, 1'b0, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
